lsu_bus_bridge: RTL and testbench

// Data-side load/store bridge directly downstream of the single-cycle core's DM stage.

---
 rtl/lsu_bus_bridge.sv | 160 ++++++++++++++++
 tb/tb_lsu_bus_bridge.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the core's DM stage and a valid/ready request + response data bus.
// Holds the core stalled until each access completes, is rejected as misaligned, or times out.
module lsu_bus_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        core_rd,
   input  logic        core_wr,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   input  logic [2:0]  core_funct,
   output logic [31:0] core_rdata,
   output logic        core_stall,
   output logic        core_misalign,
   output logic        core_timeout,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_rsp_valid,
   input  logic [31:0] bus_rsp_data
);
   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [2:0]       funct, funct_nx;
   logic [1:0]       lane, lane_nx;
   logic             we_nx, misalign_nx, timeout_nx;
   logic [31:0]      addr_nx, wdata_nx, rdata_nx;
   logic [3:0]       be_nx;

   logic             req, misaligned;
   logic [31:0]      wdata_lane, load_ext;
   logic [3:0]       be_lane;
   logic [15:0]      rsp_low;

   assign req           = core_rd | core_wr;
   assign core_stall    = ((state == IDLE) & req) | (state == REQ) | (state == RSP);
   assign bus_req_valid = (state == REQ);

   // Alignment check, store lane replication and byte enables for the incoming access.
   always_comb begin
      wdata_lane = core_wdata;
      be_lane    = 4'b1111;
      misaligned = 1'b0;
      case (core_funct[1:0])
         2'b00: begin
            wdata_lane = {4{core_wdata[7:0]}};
            be_lane    = 4'b0001 << core_addr[1:0];
         end
         2'b01: begin
            wdata_lane = {2{core_wdata[15:0]}};
            be_lane    = 4'b0011 << core_addr[1:0];
            misaligned = core_addr[0];
         end
         default: misaligned = |core_addr[1:0];
      endcase
      if (!core_wr) be_lane = 4'b1111;
   end

   // Load data extraction from the registered lane and size.
   assign rsp_low = 16'(bus_rsp_data >> {lane, 3'b000});

   always_comb begin
      case (funct[1:0])
         2'b00:   load_ext = funct[2] ? {24'h0, rsp_low[7:0]}
                                      : {{24{rsp_low[7]}}, rsp_low[7:0]};
         2'b01:   load_ext = funct[2] ? {16'h0, rsp_low}
                                      : {{16{rsp_low[15]}}, rsp_low};
         default: load_ext = bus_rsp_data;
      endcase
   end

   // Next-state and next-register logic.
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      funct_nx    = funct;
      lane_nx     = lane;
      we_nx       = bus_we;
      addr_nx     = bus_addr;
      wdata_nx    = bus_wdata;
      be_nx       = bus_be;
      rdata_nx    = core_rdata;
      misalign_nx = 1'b0;
      timeout_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (misaligned) begin
                  state_nx    = DONE;
                  misalign_nx = 1'b1;
                  rdata_nx    = 32'h0;
               end else begin
                  state_nx = REQ;
                  we_nx    = core_wr;
                  addr_nx  = {core_addr[31:2], 2'b00};
                  wdata_nx = wdata_lane;
                  be_nx    = be_lane;
                  funct_nx = core_funct;
                  lane_nx  = core_addr[1:0];
               end
            end
         end
         REQ: begin
            cnt_nx = '0;
            if (bus_req_ready) state_nx = RSP;
         end
         RSP: begin
            if (bus_rsp_valid) begin
               state_nx = DONE;
               if (!bus_we) rdata_nx = load_ext;
            end else if (cnt == CNT_LAST) begin
               state_nx   = DONE;
               timeout_nx = 1'b1;
               rdata_nx   = 32'h0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         funct         <= '0;
         lane          <= '0;
         bus_we        <= 1'b0;
         bus_addr      <= '0;
         bus_wdata     <= '0;
         bus_be        <= '0;
         core_rdata    <= '0;
         core_misalign <= 1'b0;
         core_timeout  <= 1'b0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         funct         <= funct_nx;
         lane          <= lane_nx;
         bus_we        <= we_nx;
         bus_addr      <= addr_nx;
         bus_wdata     <= wdata_nx;
         bus_be        <= be_nx;
         core_rdata    <= rdata_nx;
         core_misalign <= misalign_nx;
         core_timeout  <= timeout_nx;
      end
   end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge: a transaction-level model predicts bus fields, load
// results, pulses and stall length; literal expectations pin the model on key vectors.
module tb_lsu_bus_bridge;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_rd, core_wr;
   logic [31:0] core_addr, core_wdata;
   logic [2:0]  core_funct;
   logic [31:0] core_rdata;
   logic        core_stall, core_misalign, core_timeout;
   logic        bus_req_valid, bus_req_ready, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_rsp_valid;
   logic [31:0] bus_rsp_data;

   int errors = 0;
   int checks = 0;
   logic [31:0] last_rdata = 32'h0;

   always #5 clk = ~clk;

   lsu_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_funct(core_funct),
      .core_rdata(core_rdata), .core_stall(core_stall),
      .core_misalign(core_misalign), .core_timeout(core_timeout),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
      .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data)
   );

   typedef struct {
      logic        rd, wr;
      logic [31:0] addr, wdata;
      logic [2:0]  funct;
      int          rdly;      // cycles of valid seen with ready low
      int          rspd;      // RSP cycle (1-based) carrying the response; -1 = none
      logic [31:0] rsp;
      bit          lit;
      logic [31:0] lit_rdata;
      logic [3:0]  lit_be;
      logic [31:0] lit_wdata;
      int          lit_stall;
   } txn_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   // ---- model ----
   function automatic int sz(input logic [2:0] f);
      if (f[1:0] == 2'b00) return 1;
      if (f[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f, input logic wr);
      int s = sz(f);
      if (!wr || s == 4) return 4'hF;
      return 4'(((1 << s) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [2:0] f);
      int s = sz(f);
      if (s == 1) return 32'(d[7:0]) * 32'h01010101;
      if (s == 2) return 32'(d[15:0]) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] r, input logic [31:0] a, input logic [2:0] f);
      int s = sz(f);
      longint v;
      if (s == 4) return r;
      v = longint'(r >> (8 * (a % 4)));
      v = v % (64'sd1 << (8 * s));
      if (!f[2] && v >= (64'sd1 << (8 * s - 1))) v = v - (64'sd1 << (8 * s));
      return 32'(v);
   endfunction

   function automatic txn_t mk(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [2:0] f, input int rdly,
                               input int rspd, input logic [31:0] r, input bit lit,
                               input logic [31:0] lrd, input logic [3:0] lbe,
                               input logic [31:0] lwd, input int lst);
      txn_t t;
      t.rd = rd; t.wr = wr; t.addr = a; t.wdata = d; t.funct = f;
      t.rdly = rdly; t.rspd = rspd; t.rsp = r; t.lit = lit;
      t.lit_rdata = lrd; t.lit_be = lbe; t.lit_wdata = lwd; t.lit_stall = lst;
      return t;
   endfunction

   // Drives one access and compares the DUT against the model every cycle.
   task automatic run(input string nm, input txn_t t);
      bit emis, eto, acc, done;
      int estall, stalls, vcnt, acnt;
      logic [31:0] erd;
      emis   = (t.addr % sz(t.funct)) != 0;
      eto    = !emis && t.rspd < 0;
      estall = emis ? 1 : 2 + t.rdly + (t.rspd < 0 ? TO : t.rspd);
      erd    = (emis || eto) ? 32'h0 : (t.wr ? last_rdata : m_load(t.rsp, t.addr, t.funct));
      stalls = 0; vcnt = 0; acnt = 0; acc = 0; done = 0;
      @(posedge clk); #1;
      core_rd = t.rd; core_wr = t.wr; core_addr = t.addr;
      core_wdata = t.wdata; core_funct = t.funct;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (!core_stall) begin
            done = 1;
         end else begin
            stalls++;
            if (bus_req_valid) begin
               vcnt++;
               chk({nm, " valid_ok"}, 32'(acc || emis), 32'h0);
               chk({nm, " we"}, 32'(bus_we), 32'(t.wr));
               chk({nm, " addr"}, bus_addr, {t.addr[31:2], 2'b00});
               chk({nm, " be"}, 32'(bus_be), 32'(m_be(t.addr, t.funct, t.wr)));
               if (t.wr) chk({nm, " wdata"}, bus_wdata, m_wdata(t.wdata, t.funct));
               if (t.lit && vcnt == 1) begin
                  chk({nm, " lit_be"}, 32'(bus_be), 32'(t.lit_be));
                  if (t.wr) chk({nm, " lit_wdata"}, bus_wdata, t.lit_wdata);
               end
               bus_req_ready = (vcnt > t.rdly);
               if (bus_req_ready) acc = 1;
            end else begin
               bus_req_ready = 1'b0;
               if (acc) begin
                  acnt++;
                  bus_rsp_valid = (t.rspd >= 0 && acnt == t.rspd);
                  bus_rsp_data  = bus_rsp_valid ? t.rsp : 32'hBAD0_0BAD;
               end
            end
         end
      end
      bus_rsp_valid = 1'b0; bus_req_ready = 1'b0;
      core_rd = 1'b0; core_wr = 1'b0;
      if (!done) chk({nm, " done_reached"}, 32'h0, 32'h1);
      chk({nm, " stall_cycles"}, 32'(stalls), 32'(estall));
      chk({nm, " rdata"}, core_rdata, erd);
      chk({nm, " misalign"}, 32'(core_misalign), 32'(emis));
      chk({nm, " timeout"}, 32'(core_timeout), 32'(eto));
      chk({nm, " valid_in_done"}, 32'(bus_req_valid), 32'h0);
      if (t.lit) begin
         chk({nm, " lit_rdata"}, core_rdata, t.lit_rdata);
         chk({nm, " lit_stall"}, 32'(stalls), 32'(t.lit_stall));
      end
      // Following cycle: pulses gone, result held; a late response must be ignored.
      if (eto) begin
         bus_rsp_valid = 1'b1;
         bus_rsp_data  = 32'h5555_5555;
      end
      @(negedge clk);
      bus_rsp_valid = 1'b0;
      chk({nm, " post_pulses"}, 32'({core_misalign, core_timeout, core_stall, bus_req_valid}), 32'h0);
      chk({nm, " post_rdata"}, core_rdata, erd);
      last_rdata = erd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      core_rd = 0; core_wr = 0; core_addr = 0; core_wdata = 0; core_funct = 0;
      bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_data = 0;
      repeat (2) @(negedge clk);
      chk("reset rdata", core_rdata, 32'h0);
      chk("reset ctl", 32'({core_stall, core_misalign, core_timeout, bus_req_valid, bus_we}), 32'h0);
      chk("reset addr", bus_addr, 32'h0);
      chk("reset wdata", bus_wdata, 32'h0);
      chk("reset be", 32'(bus_be), 32'h0);
      reset = 1'b0;

      run("lw100",  mk(1, 0, 32'h100, 0, 3'b010, 0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 4'hF, 0, 3));
      run("lb103",  mk(1, 0, 32'h103, 0, 3'b000, 0, 1, 32'h80FF0000, 1, 32'hFFFFFF80, 4'hF, 0, 3));
      run("lbu103", mk(1, 0, 32'h103, 0, 3'b100, 0, 1, 32'h80FF0000, 1, 32'h00000080, 4'hF, 0, 3));
      run("sh202",  mk(0, 1, 32'h202, 32'h1234ABCD, 3'b001, 0, 1, 0, 1, 32'h00000080, 4'hC, 32'hABCDABCD, 3));
      run("lw101",  mk(1, 0, 32'h101, 0, 3'b010, 0, 1, 32'h11111111, 1, 32'h0, 4'hF, 0, 1));
      run("sw_wait", mk(0, 1, 32'h300, 32'hCAFEF00D, 3'b010, 5, 2, 0, 1, 32'h0, 4'hF, 32'hCAFEF00D, 9));
      run("lh302",  mk(1, 0, 32'h302, 0, 3'b001, 1, 1, 32'h80017FFF, 1, 32'hFFFF8001, 4'hF, 0, 4));
      run("lhu000", mk(1, 0, 32'h000, 0, 3'b101, 0, 3, 32'h1234F00D, 1, 32'h0000F00D, 4'hF, 0, 5));
      run("sb007",  mk(0, 1, 32'h007, 32'h000000A5, 3'b000, 0, 1, 0, 1, 32'h0000F00D, 4'h8, 32'hA5A5A5A5, 3));
      run("lw_to",  mk(1, 0, 32'h104, 0, 3'b010, 0, -1, 0, 1, 32'h0, 4'hF, 0, 10));
      run("f011",   mk(1, 0, 32'h104, 0, 3'b011, 0, 1, 32'h11223344, 1, 32'h11223344, 4'hF, 0, 3));
      run("f110mis", mk(1, 0, 32'h106, 0, 3'b110, 0, 1, 0, 0, 0, 4'hF, 0, 0));
      run("lh301",  mk(1, 0, 32'h301, 0, 3'b001, 0, 1, 0, 0, 0, 4'hF, 0, 0));
      run("rdwr",   mk(1, 1, 32'h010, 32'h0BADCAFE, 3'b010, 2, 2, 32'hFFFFFFFF, 1, 32'h0, 4'hF, 32'h0BADCAFE, 6));
      run("lb_rand", mk(1, 0, 32'h0A1, 0, 3'b000, 0, 2, 32'h12345678, 0, 0, 4'hF, 0, 0));

      // Reset asserted while waiting for a response.
      @(posedge clk); #1;
      core_rd = 1; core_addr = 32'h400; core_funct = 3'b010;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid in_req", 32'(bus_req_valid), 32'h1);
      bus_req_ready = 1'b1;
      @(negedge clk);
      bus_req_ready = 1'b0; core_rd = 1'b0;
      chk("rst_mid in_rsp", 32'({core_stall, bus_req_valid}), 32'h2);
      reset = 1'b1; #1;
      chk("rst_mid ctl", 32'({core_stall, core_misalign, core_timeout, bus_req_valid, bus_we}), 32'h0);
      chk("rst_mid addr", bus_addr, 32'h0);
      chk("rst_mid be", 32'(bus_be), 32'h0);
      chk("rst_mid rdata", core_rdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      bus_rsp_valid = 1'b1; bus_rsp_data = 32'h77777777;
      @(negedge clk);
      bus_rsp_valid = 1'b0;
      chk("rst_mid stray", 32'({core_stall, bus_req_valid}), 32'h0);
      chk("rst_mid stray_rdata", core_rdata, 32'h0);
      last_rdata = 32'h0;
      run("recover", mk(1, 0, 32'h100, 0, 3'b010, 0, 1, 32'h00C0FFEE, 1, 32'h00C0FFEE, 4'hF, 0, 3));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
